display_scheduler: RTL and testbench

- Owns the four-digit seven-segment display and shares it between N_SRC 32-bit sources, e.g. PC, ALU result or a selected register.
- Sources are selected by a button or by auto-rotation on a dwell timer.
- Performs an iterative double-dabble binary-to-BCD conversion and drives registered, glitch-free segment outputs.
- Sits between CPU debug taps and the board's HEX pins.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/display_scheduler_if.sv | 32 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/display_scheduler.sv | 128 ++++++++++++
 tb/tb_display_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types for the display scheduler: controller states and the
// active-low seven-segment glyph table (bit order gfedcba).
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Nibbles above 9 cannot come out of a correct double-dabble; show blank.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Signal bundle between the debug taps / board controls and the display
// scheduler; state is exported so checkers can follow the controller.
interface display_scheduler_if #(
  parameter int N_SRC = 4
);
  import display_pkg::*;

  localparam int IW = $clog2(N_SRC);

  logic [32*N_SRC-1:0] src_values;
  logic                next_btn;
  logic                auto_mode;
  logic                freeze;
  logic [6:0]          hex0;
  logic [6:0]          hex1;
  logic [6:0]          hex2;
  logic [6:0]          hex3;
  logic [IW-1:0]       disp_idx;
  logic                busy;
  state_t              state;

  modport master (
    output src_values, next_btn, auto_mode, freeze,
    input  hex0, hex1, hex2, hex3, disp_idx, busy, state
  );

  modport slave (
    input  src_values, next_btn, auto_mode, freeze,
    output hex0, hex1, hex2, hex3, disp_idx, busy, state
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one 32-bit binary value to ten BCD digits,
// one shift per clock, 32 shifts per conversion.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] bin_in_i,
  output logic        done_o,
  output logic [39:0] bcd_out_o
);

  logic [31:0] sr_q, sr_d;
  logic [39:0] bcd_q, bcd_d;
  logic [39:0] bcd_adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;

  // start_i is a one-cycle request that is always accepted and restarts the
  // engine; done_o is high during the final shift, so bcd_out_o holds the
  // finished result from the next cycle until the following start_i.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    sr_d  = sr_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      sr_d  = bin_in_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
      cnt_d         = cnt_q + 5'd1;
      if (cnt_q == 5'd31) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o    = run_q && (cnt_q == 5'd31);
  assign bcd_out_o = bcd_q;

endmodule

// File: rtl/display_scheduler.sv
// Shares the four-digit display between N_SRC 32-bit sources: selection,
// dwell/refresh timers, conversion sequencing and glitch-free output registers.
module display_scheduler
  import display_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int DWELL_CYCLES   = 50_000_000,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input logic                clk,
  input logic                rst,
  display_scheduler_if.slave dif
);

  localparam int IW = $clog2(N_SRC);
  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam int RW = $clog2(REFRESH_CYCLES) + 1;

  localparam logic [IW-1:0] LAST_IDX     = IW'(N_SRC - 1);
  localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  state_t        state_q;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] cvt_idx_q;
  logic [IW-1:0] disp_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          pending_q, pending_d;
  logic          busy_q;
  logic [6:0]    hex0_q, hex1_q, hex2_q, hex3_q;

  logic          dwell_exp;
  logic          advance;
  logic          refresh_wrap;
  logic          start_cvt;
  logic          engine_start;
  logic          cvt_done;
  logic [31:0]   cvt_bin;
  logic [39:0]   cvt_bcd;
  logic [23:0]   unused_bcd_hi;

  // A button press and a dwell expiry on the same cycle collapse into one step.
  always_comb begin
    dwell_exp    = dif.auto_mode && (dwell_q == DWELL_LAST);
    advance      = dif.next_btn || dwell_exp;
    refresh_wrap = (refresh_q == REFRESH_LAST);
    start_cvt    = (state_q == IDLE) && pending_q && !dif.freeze;

    sel_d = sel_q;
    if (advance) sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
    dwell_d   = (!dif.auto_mode || advance) ? '0 : dwell_q + 1'b1;
    refresh_d = refresh_wrap ? '0 : refresh_q + 1'b1;
    // Events arriving on the start cycle must survive the clear.
    pending_d = (pending_q && !start_cvt) || advance || refresh_wrap;
  end

  assign cvt_bin       = dif.src_values[32*sel_q +: 32];
  assign engine_start  = (state_q == LOAD);
  assign unused_bcd_hi = cvt_bcd[39:16];

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .start_i   (engine_start),
    .bin_in_i  (cvt_bin),
    .done_o    (cvt_done),
    .bcd_out_o (cvt_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cvt_idx_q <= '0;
      disp_q    <= '0;
      dwell_q   <= '0;
      refresh_q <= '0;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      hex0_q    <= SEG_0;
      hex1_q    <= SEG_0;
      hex2_q    <= SEG_0;
      hex3_q    <= SEG_0;
    end else begin
      sel_q     <= sel_d;
      dwell_q   <= dwell_d;
      refresh_q <= refresh_d;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (start_cvt) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          cvt_idx_q <= sel_q;
          state_q   <= SHIFT;
        end
        SHIFT: begin
          if (cvt_done) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          hex0_q  <= seg7_encode(cvt_bcd[3:0]);
          hex1_q  <= seg7_encode(cvt_bcd[7:4]);
          hex2_q  <= seg7_encode(cvt_bcd[11:8]);
          hex3_q  <= seg7_encode(cvt_bcd[15:12]);
          disp_q  <= cvt_idx_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.hex0     = hex0_q;
  assign dif.hex1     = hex1_q;
  assign dif.hex2     = hex2_q;
  assign dif.hex3     = hex3_q;
  assign dif.disp_idx = disp_q;
  assign dif.busy     = busy_q;
  assign dif.state    = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus random traffic, checked
// against a cycle-level reference that converts with plain mod/div arithmetic.
module tb_display_scheduler;
  import display_pkg::*;

  localparam int N_SRC   = 4;
  localparam int DWELL   = 8;
  localparam int REFRESH = 64;
  localparam int LAT     = 34;

  localparam logic [6:0] SEG_REF [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [27:0] H_0000 = {4{7'b1000000}};
  localparam logic [27:0] H_2345 = {7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010};
  localparam logic [27:0] H_7295 = {7'b1111000, 7'b0100100, 7'b0010000, 7'b0010010};
  localparam logic [27:0] H_9999 = {4{7'b0010000}};
  localparam logic [27:0] H_0042 = {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100};
  localparam logic [27:0] H_8888 = {4{7'b0000000}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_scheduler_if #(.N_SRC(N_SRC)) dif ();

  display_scheduler #(
    .N_SRC          (N_SRC),
    .DWELL_CYCLES   (DWELL),
    .REFRESH_CYCLES (REFRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          armed = 1'b0;
  int          m_sel, m_dwell, m_refresh, m_left, m_cidx, m_disp;
  bit          m_pending, m_busy;
  logic [27:0] m_hex;
  logic [27:0] m_cvt_hex;
  logic [63:0] exp_q[$];

  function automatic logic [27:0] hex_of(input logic [31:0] v);
    logic [27:0] h;
    int          r;
    h = '0;
    r = int'(v % 32'd10000);
    for (int k = 0; k < 4; k++) begin
      h[7*k +: 7] = SEG_REF[r % 10];
      r = r / 10;
    end
    return h;
  endfunction

  always @(posedge clk) begin
    bit adv, wrap, start;
    cyc++;
    if (rst) begin
      armed     = 1'b1;
      m_sel     = 0;
      m_dwell   = 0;
      m_refresh = 0;
      m_left    = 0;
      m_cidx    = 0;
      m_disp    = 0;
      m_pending = 1'b1;
      m_busy    = 1'b0;
      m_hex     = H_0000;
      m_cvt_hex = H_0000;
      exp_q.delete();
    end else if (armed) begin
      adv   = dif.next_btn || (dif.auto_mode && m_dwell == DWELL - 1);
      wrap  = (m_refresh == REFRESH - 1);
      start = (m_left == 0) && m_pending && !dif.freeze;
      if (m_left > 0) begin
        if (m_left == LAT) begin
          m_cidx    = m_sel;
          m_cvt_hex = hex_of(dif.src_values[32*m_sel +: 32]);
          exp_q.push_back({32'(cyc + LAT - 1), 4'(m_cidx), m_cvt_hex});
        end
        m_left--;
        if (m_left == 0) begin
          m_hex  = m_cvt_hex;
          m_disp = m_cidx;
        end
      end else if (start) begin
        m_left = LAT;
      end
      m_pending = (m_pending && !start) || adv || wrap;
      m_sel     = adv ? (m_sel + 1) % N_SRC : m_sel;
      m_dwell   = (!dif.auto_mode || adv) ? 0 : m_dwell + 1;
      m_refresh = wrap ? 0 : m_refresh + 1;
      m_busy    = (m_left >= 2);
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit prev_done = 1'b0;

  always @(posedge clk) begin
    logic [27:0] got_hex;
    logic [63:0] e;
    #1;
    if (armed) begin
      got_hex = {dif.hex3, dif.hex2, dif.hex1, dif.hex0};
      checks++;
      if (got_hex !== m_hex || int'(dif.disp_idx) != m_disp || dif.busy !== m_busy) begin
        errors++;
        $display("FAIL outputs @%0d: got hex=%h idx=%0d busy=%b expected hex=%h idx=%0d busy=%b",
                 cyc, got_hex, dif.disp_idx, dif.busy, m_hex, m_disp, m_busy);
      end
      if (prev_done && !rst) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected @%0d: got a commit, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (int'(e[63:32]) != cyc || int'(dif.disp_idx) != int'(e[31:28]) || got_hex !== e[27:0]) begin
            errors++;
            $display("FAIL commit @%0d: got idx=%0d hex=%h expected cycle=%0d idx=%0d hex=%h",
                     cyc, dif.disp_idx, got_hex, e[63:32], e[31:28], e[27:0]);
          end
        end
      end
      while (exp_q.size() > 0 && int'(exp_q[0][63:32]) < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL commit_missing @%0d: got no commit, expected one at cycle %0d", cyc, e[63:32]);
      end
    end
    prev_done = (dif.state == DONE);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    dif.src_values[32*k +: 32] = v;
  endtask

  task automatic pulse_next();
    dif.next_btn = 1'b1;
    @(negedge clk);
    dif.next_btn = 1'b0;
  endtask

  task automatic wait_left(input int target, input string name);
    int n = 0;
    while (m_left != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_left != target) begin
      checks++;
      errors++;
      $display("FAIL %s: got timeout, expected conversion step %0d", name, target);
    end
  endtask

  function automatic logic [27:0] shown();
    return {dif.hex3, dif.hex2, dif.hex1, dif.hex0};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt, n, s0, s_old, s_new;
    dif.src_values = '0;
    dif.next_btn   = 1'b0;
    dif.auto_mode  = 1'b0;
    dif.freeze     = 1'b0;
    set_src(0, 32'd12345);
    set_src(1, 32'd0);
    set_src(2, 32'd4294967295);
    set_src(3, $urandom);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hex", 32'(shown()), 32'(H_0000));
    chk("reset_idx", 32'(dif.disp_idx), 0);
    chk("reset_busy", 32'(dif.busy), 0);
    rst = 1'b0;

    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.busy) busy_cnt++;
    end
    chk("first_busy_cycles", busy_cnt, 33);
    chk("first_hex_2345", 32'(shown()), 32'(H_2345));
    chk("first_idx", 32'(dif.disp_idx), 0);

    pulse_next();
    repeat (75) @(negedge clk);
    chk("src1_idx", 32'(dif.disp_idx), 1);
    chk("src1_hex_0000", 32'(shown()), 32'(H_0000));
    pulse_next();
    repeat (75) @(negedge clk);
    chk("src2_idx", 32'(dif.disp_idx), 2);
    chk("src2_hex_7295", 32'(shown()), 32'(H_7295));
    pulse_next();
    repeat (75) @(negedge clk);
    chk("src3_idx", 32'(dif.disp_idx), 3);
    pulse_next();
    repeat (75) @(negedge clk);
    chk("wrap_idx", 32'(dif.disp_idx), 0);

    // Button on the exact dwell-expiry cycle.
    dif.auto_mode = 1'b1;
    n = 0;
    while (m_dwell != DWELL - 1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("dwell_reached", 32'(m_dwell), 32'(DWELL - 1));
    s0 = m_sel;
    dif.next_btn = 1'b1;
    @(negedge clk);
    dif.next_btn  = 1'b0;
    dif.auto_mode = 1'b0;
    repeat (75) @(negedge clk);
    chk("collide_single_step", 32'(dif.disp_idx), 32'((s0 + 1) % N_SRC));

    // Button during SHIFT.
    pulse_next();
    wait_left(LAT - 10, "shift_wait");
    s_old = m_cidx;
    s_new = (m_sel + 1) % N_SRC;
    pulse_next();
    n = 0;
    while (dif.state != DONE && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("mid_done_seen", 32'(dif.state == DONE), 1);
    @(negedge clk);
    chk("mid_old_idx", 32'(dif.disp_idx), 32'(s_old));
    @(negedge clk);
    chk("mid_restart_busy", 32'(dif.busy), 1);
    repeat (34) @(negedge clk);
    chk("mid_new_idx", 32'(dif.disp_idx), 32'(s_new));

    // Freeze holds the display while the source changes.
    set_src(0, 32'd9999);
    for (int k = 0; k < N_SRC; k++) if (m_sel != 0) pulse_next();
    repeat (75) @(negedge clk);
    chk("pre_freeze_9999", 32'(shown()), 32'(H_9999));
    dif.freeze = 1'b1;
    repeat (40) @(negedge clk);
    set_src(0, 32'd42);
    repeat (3 * REFRESH) @(negedge clk);
    chk("freeze_hold_9999", 32'(shown()), 32'(H_9999));
    chk("freeze_idle", 32'(dif.busy), 0);
    dif.freeze = 1'b0;
    repeat (36) @(negedge clk);
    chk("unfreeze_0042", 32'(shown()), 32'(H_0042));

    // Reset in the middle of a conversion.
    for (int k = 0; k < N_SRC; k++) set_src(k, 32'd8888);
    wait_left(LAT - 20, "reset_wait");
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_hex", 32'(shown()), 32'(H_0000));
    chk("midreset_idx", 32'(dif.disp_idx), 0);
    chk("midreset_busy", 32'(dif.busy), 0);
    rst = 1'b0;
    repeat (36) @(negedge clk);
    chk("after_reset_8888", 32'(shown()), 32'(H_8888));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      dif.next_btn = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) dif.auto_mode = ~dif.auto_mode;
      if ($urandom_range(0, 149) == 0) dif.freeze = ~dif.freeze;
      if ($urandom_range(0, 9) == 0) set_src($urandom_range(0, N_SRC - 1), $urandom);
      rst = ($urandom_range(0, 399) == 0);
    end

    @(negedge clk);
    dif.next_btn  = 1'b0;
    dif.auto_mode = 1'b0;
    dif.freeze    = 1'b1;
    rst           = 1'b0;
    repeat (40) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
